// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the int_ctrl interrupt controller.
package int_ctrl_pkg;

  localparam int unsigned DEF_NUM_SRC = 8;
  localparam int unsigned DEF_ID_W    = 3;
  localparam int unsigned REG_W       = 32;

  // Register window word offsets
  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_MODE    = 2'd3;

  // STATUS register bit positions
  localparam int unsigned STATUS_INSVC_BIT = 31;
  localparam int unsigned STATUS_INT_BIT   = 30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder: bit 0 is the highest priority.
module int_prio_enc #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] vec,
  output logic         valid_c,
  output logic [W-1:0] id_c
);

  // Scan from the top so the lowest set index is written last and wins
  always_comb begin
    valid_c = |vec;
    id_c    = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec[i]) id_c = W'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge/level capture, masking, priority select and
// request/ack/eoi handshake toward the CPU INT line, plus a 4-word register
// window. Optional macro INT_CTRL_SYNC_EN adds a 2-flop synchronizer on
// every irq_src line ahead of edge detection.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned ID_W    = DEF_ID_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               reg_sel,
  input  logic [1:0]         reg_addr,
  input  logic               reg_we,
  input  logic [REG_W-1:0]   reg_wdata,
  output logic [REG_W-1:0]   reg_rdata,
  output logic               INT,
  output logic [ID_W-1:0]    int_id,
  input  logic               int_ack,
  input  logic               eoi
);

  logic [NUM_SRC-1:0] src_s;

`ifdef INT_CTRL_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync1_d;
  logic [NUM_SRC-1:0] sync2_q, sync2_d;

  // Synchronizer next-state
  always_comb begin
    sync1_d = irq_src;
    sync2_d = sync1_q;
  end

  // Two-flop synchronizer on every source line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = irq_src;
`endif

  logic [NUM_SRC-1:0] src_q, src_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] rise_c, req_vec_c, w1c_c, ack_clr_c;
  state_e             state_q, state_d;
  logic               int_q, int_d;
  logic [ID_W-1:0]    int_id_q, int_id_d;
  logic               win_valid_c;
  logic [ID_W-1:0]    win_id_c;
  logic               wr_c;
  logic               unused_wdata;

  assign wr_c         = reg_sel & reg_we;
  assign rise_c       = src_s & ~src_q;
  assign req_vec_c    = pending_q & mask_q;
  assign unused_wdata = ^reg_wdata[REG_W-1:NUM_SRC];

  int_prio_enc #(
    .N (NUM_SRC),
    .W (ID_W)
  ) u_prio (
    .vec     (req_vec_c),
    .valid_c (win_valid_c),
    .id_c    (win_id_c)
  );

  // Register writes and pending capture; a new edge beats a same-cycle clear
  always_comb begin
    src_d  = src_s;
    mask_d = mask_q;
    mode_d = mode_q;
    w1c_c  = '0;
    if (wr_c) begin
      case (reg_addr)
        REG_PENDING: w1c_c  = reg_wdata[NUM_SRC-1:0];
        REG_MASK:    mask_d = reg_wdata[NUM_SRC-1:0];
        REG_MODE:    mode_d = reg_wdata[NUM_SRC-1:0];
        default:     ;
      endcase
    end
    pending_d = (mode_q & ((pending_q & ~(w1c_c | ack_clr_c)) | rise_c))
              | (~mode_q & src_s);
  end

  // Handshake FSM: arbitrate in IDLE, hold ID in REQ, wait for eoi in SERVICE
  always_comb begin
    state_d   = state_q;
    int_d     = int_q;
    int_id_d  = int_id_q;
    ack_clr_c = '0;
    case (state_q)
      IDLE: begin
        if (win_valid_c) begin
          state_d  = REQ;
          int_d    = 1'b1;
          int_id_d = win_id_c;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d   = SERVICE;
          int_d     = 1'b0;
          ack_clr_c = NUM_SRC'(1) << int_id_q;
        end else if (!req_vec_c[int_id_q]) begin
          state_d = IDLE;
          int_d   = 1'b0;
        end
      end
      SERVICE: begin
        int_d = 1'b0;
        if (eoi) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        int_d   = 1'b0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      state_q   <= IDLE;
      int_q     <= 1'b0;
      int_id_q  <= '0;
    end else begin
      src_q     <= src_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      state_q   <= state_d;
      int_q     <= int_d;
      int_id_q  <= int_id_d;
    end
  end

  // Combinational read mux; idle bus reads as zero
  always_comb begin
    reg_rdata = '0;
    if (reg_sel) begin
      case (reg_addr)
        REG_PENDING: reg_rdata = REG_W'(pending_q);
        REG_MASK:    reg_rdata = REG_W'(mask_q);
        REG_STATUS: begin
          reg_rdata[STATUS_INSVC_BIT] = (state_q == SERVICE);
          reg_rdata[STATUS_INT_BIT]   = int_q;
          reg_rdata[ID_W-1:0]         = int_id_q;
        end
        REG_MODE:    reg_rdata = REG_W'(mode_q);
        default:     reg_rdata = '0;
      endcase
    end
  end

  assign INT    = int_q;
  assign int_id = int_id_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl (default build, no synchronizer).
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_src;
  logic        reg_sel;
  logic [1:0]  reg_addr;
  logic        reg_we;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        INT;
  logic [2:0]  int_id;
  logic        int_ack;
  logic        eoi;

  int_ctrl #(.NUM_SRC(8), .ID_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .reg_sel   (reg_sel),
    .reg_addr  (reg_addr),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .INT       (INT),
    .int_id    (int_id),
    .int_ack   (int_ack),
    .eoi       (eoi)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  irq;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic        ack;
    logic        eoi;
    logic        e_int;
    logic [2:0]  e_id;
    logic [7:0]  e_pend;
    logic [31:0] e_stat;
  } vec_t;

  typedef struct packed {
    logic        e_int;
    logic [2:0]  e_id;
    logic [7:0]  e_pend;
    logic [31:0] e_stat;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(logic [7:0] irq, logic we, logic [1:0] addr,
                              logic [31:0] wd, logic ack, logic e,
                              logic ei, logic [2:0] eid, logic [7:0] ep,
                              logic [31:0] es);
    vec_t v;
    v.irq = irq; v.we = we; v.addr = addr; v.wd = wd; v.ack = ack; v.eoi = e;
    v.e_int = ei; v.e_id = eid; v.e_pend = ep; v.e_stat = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    reg_sel = 1'b1;
    reg_we  = 1'b0;
    reg_addr = a;
    #1;
    d = reg_rdata;
    reg_sel = 1'b0;
  endtask

  // Drive one vector, queue its expectation, compare after the edge
  task automatic step(input vec_t v, input int idx);
    exp_t        e;
    logic [31:0] d;
    irq_src   = v.irq;
    reg_sel   = v.we;
    reg_we    = v.we;
    reg_addr  = v.addr;
    reg_wdata = v.wd;
    int_ack   = v.ack;
    eoi       = v.eoi;
    exp_q.push_back({v.e_int, v.e_id, v.e_pend, v.e_stat});
    @(posedge clk);
    #1;
    reg_we = 1'b0; reg_sel = 1'b0; int_ack = 1'b0; eoi = 1'b0;
    e = exp_q.pop_front();
    check($sformatf("v%0d INT", idx), 32'(INT), 32'(e.e_int));
    check($sformatf("v%0d int_id", idx), 32'(int_id), 32'(e.e_id));
    rd(2'd0, d);
    check($sformatf("v%0d PENDING", idx), d, 32'(e.e_pend));
    rd(2'd2, d);
    check($sformatf("v%0d STATUS", idx), d, e.e_stat);
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b1; irq_src = '0; reg_sel = 1'b0; reg_addr = '0; reg_we = 1'b0;
    reg_wdata = '0; int_ack = 1'b0; eoi = 1'b0;

    // irq, we, addr, wdata, ack, eoi | INT, id, PENDING, STATUS
    // single edge source 0
    vecs.push_back(mk(8'h00,1,2'd1,32'h01,0,0, 0,3'd0,8'h00,32'h0));
    vecs.push_back(mk(8'h00,1,2'd3,32'h01,0,0, 0,3'd0,8'h00,32'h0));
    vecs.push_back(mk(8'h01,0,2'd0,32'h00,0,0, 0,3'd0,8'h01,32'h0));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,0,0, 1,3'd0,8'h01,32'h4000_0000));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,1,0, 0,3'd0,8'h00,32'h8000_0000));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,0,0, 0,3'd0,8'h00,32'h8000_0000));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,0,1, 0,3'd0,8'h00,32'h0));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,0,0, 0,3'd0,8'h00,32'h0));
    // sources 5 and 2 together, all edge mode
    vecs.push_back(mk(8'h00,1,2'd1,32'hFF,0,0, 0,3'd0,8'h00,32'h0));
    vecs.push_back(mk(8'h00,1,2'd3,32'hFF,0,0, 0,3'd0,8'h00,32'h0));
    vecs.push_back(mk(8'h24,0,2'd0,32'h00,0,0, 0,3'd0,8'h24,32'h0));
    vecs.push_back(mk(8'h24,0,2'd0,32'h00,0,0, 1,3'd2,8'h24,32'h4000_0002));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,1,0, 0,3'd2,8'h20,32'h8000_0002));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,0,1, 0,3'd2,8'h20,32'h0000_0002));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,0,0, 1,3'd5,8'h20,32'h4000_0005));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,1,0, 0,3'd5,8'h00,32'h8000_0005));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,0,1, 0,3'd5,8'h00,32'h0000_0005));
    // no preemption: src 4 in REQ, src 1 arrives
    vecs.push_back(mk(8'h10,0,2'd0,32'h00,0,0, 0,3'd5,8'h10,32'h0000_0005));
    vecs.push_back(mk(8'h10,0,2'd0,32'h00,0,0, 1,3'd4,8'h10,32'h4000_0004));
    vecs.push_back(mk(8'h12,0,2'd0,32'h00,0,0, 1,3'd4,8'h12,32'h4000_0004));
    vecs.push_back(mk(8'h12,0,2'd0,32'h00,0,0, 1,3'd4,8'h12,32'h4000_0004));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,1,0, 0,3'd4,8'h02,32'h8000_0004));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,0,1, 0,3'd4,8'h02,32'h0000_0004));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,0,0, 1,3'd1,8'h02,32'h4000_0001));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,1,0, 0,3'd1,8'h00,32'h8000_0001));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,0,1, 0,3'd1,8'h00,32'h0000_0001));
    // W1C on src 6 racing a new edge: set wins, then plain clear
    vecs.push_back(mk(8'h00,1,2'd1,32'h00,0,0, 0,3'd1,8'h00,32'h0000_0001));
    vecs.push_back(mk(8'h40,0,2'd0,32'h00,0,0, 0,3'd1,8'h40,32'h0000_0001));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,0,0, 0,3'd1,8'h40,32'h0000_0001));
    vecs.push_back(mk(8'h40,1,2'd0,32'h40,0,0, 0,3'd1,8'h40,32'h0000_0001));
    vecs.push_back(mk(8'h40,1,2'd0,32'h40,0,0, 0,3'd1,8'h00,32'h0000_0001));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,0,0, 0,3'd1,8'h00,32'h0000_0001));
    // level src 3, withdrawal while in REQ
    vecs.push_back(mk(8'h00,1,2'd3,32'h00,0,0, 0,3'd1,8'h00,32'h0000_0001));
    vecs.push_back(mk(8'h00,1,2'd1,32'h08,0,0, 0,3'd1,8'h00,32'h0000_0001));
    vecs.push_back(mk(8'h08,0,2'd0,32'h00,0,0, 0,3'd1,8'h08,32'h0000_0001));
    vecs.push_back(mk(8'h08,0,2'd0,32'h00,0,0, 1,3'd3,8'h08,32'h4000_0003));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,0,0, 1,3'd3,8'h00,32'h4000_0003));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,0,0, 0,3'd3,8'h00,32'h0000_0003));
    // level: W1C ignored, ack outside REQ ignored, ack does not clear level
    vecs.push_back(mk(8'h08,1,2'd0,32'h08,0,0, 0,3'd3,8'h08,32'h0000_0003));
    vecs.push_back(mk(8'h08,0,2'd0,32'h00,1,0, 1,3'd3,8'h08,32'h4000_0003));
    vecs.push_back(mk(8'h08,0,2'd0,32'h00,1,0, 0,3'd3,8'h08,32'h8000_0003));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,0,1, 0,3'd3,8'h00,32'h0000_0003));
    vecs.push_back(mk(8'h00,0,2'd0,32'h00,0,0, 0,3'd3,8'h00,32'h0000_0003));
    // back into SERVICE ahead of the reset sequence
    vecs.push_back(mk(8'h08,0,2'd0,32'h00,0,0, 0,3'd3,8'h08,32'h0000_0003));
    vecs.push_back(mk(8'h08,0,2'd0,32'h00,0,0, 1,3'd3,8'h08,32'h4000_0003));
    vecs.push_back(mk(8'h08,0,2'd0,32'h00,1,0, 0,3'd3,8'h08,32'h8000_0003));

    // reset state
    #12;
    check("rst INT", 32'(INT), 32'h0);
    check("rst int_id", 32'(int_id), 32'h0);
    rd(2'd0, d); check("rst PENDING", d, 32'h0);
    rd(2'd1, d); check("rst MASK", d, 32'h0);
    rd(2'd2, d); check("rst STATUS", d, 32'h0);
    rd(2'd3, d); check("rst MODE", d, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // unselected window reads zero while MASK is nonzero
    reg_sel = 1'b0; reg_addr = 2'd1; #1;
    check("rdata unselected", reg_rdata, 32'h0);

    // asynchronous reset from SERVICE, mid-cycle
    #2;
    reset = 1'b1;
    #1;
    check("arst INT", 32'(INT), 32'h0);
    check("arst int_id", 32'(int_id), 32'h0);
    rd(2'd0, d); check("arst PENDING", d, 32'h0);
    rd(2'd1, d); check("arst MASK", d, 32'h0);
    rd(2'd2, d); check("arst STATUS", d, 32'h0);
    irq_src = '0;
    #1;
    reset = 1'b0;
    eoi = 1'b1;
    @(posedge clk); #1;
    eoi = 1'b0;
    @(posedge clk); #1;
    check("post-rst INT", 32'(INT), 32'h0);
    rd(2'd2, d); check("post-rst STATUS", d, 32'h0);
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
